// File: rtl/brush_painter.sv
// brush_painter: per-pixel brush stroke painter feeding the canvas frame store.
// Define BRUSH_ROUND_EN for a round brush (adds one pipeline stage, 2-cycle latency).
module brush_painter #(
  parameter int CANVAS_X0 = 100,
  parameter int CANVAS_Y0 = 100,
  parameter int CANVAS_W  = 440,
  parameter int CANVAS_H  = 280,
  parameter int MAX_SIZE  = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       VS,
  input  logic [9:0] xPos,
  input  logic [9:0] yPos,
  input  logic [7:0] Rc,
  input  logic [7:0] Gc,
  input  logic [7:0] Bc,
  input  logic [9:0] mouseX,
  input  logic [9:0] mouseY,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnClr,
  input  logic [2:0] colSel,
  input  logic       sizeUp,
  input  logic       sizeDn,
  output logic [7:0] Ri,
  output logic [7:0] Gi,
  output logic [7:0] Bi,
  output logic [9:0] xOut,
  output logic [9:0] yOut
);
  localparam int SW = $clog2(MAX_SIZE + 1);
  localparam logic [10:0] X_LO = 11'(CANVAS_X0);
  localparam logic [10:0] X_HI = 11'(CANVAS_X0 + CANVAS_W);
  localparam logic [10:0] Y_LO = 11'(CANVAS_Y0);
  localparam logic [10:0] Y_HI = 11'(CANVAS_Y0 + CANVAS_H);

  typedef enum logic [1:0] {IDLE, DRAW, ERASE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          vs_q, clr_q;
  logic          clr_pend_q, clr_pend_d;
  logic [SW-1:0] size_q, size_d;
  logic [23:0]   colour_q, colour_d;
  logic [9:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic          fb, clr_edge;

  assign fb       = vs_q & ~VS;
  assign clr_edge = btnClr & ~clr_q;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 24'h000000;
      3'd1:    palette = 24'hFFFFFF;
      3'd2:    palette = 24'hFF0000;
      3'd3:    palette = 24'h00FF00;
      3'd4:    palette = 24'h0000FF;
      3'd5:    palette = 24'hFFFF00;
      3'd6:    palette = 24'h00FFFF;
      default: palette = 24'hFF00FF;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q | clr_edge;
    size_d     = size_q;
    colour_d   = colour_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    if (fb) begin
      // a clear edge arriving in the FB cycle itself is consumed right away
      clr_pend_d = 1'b0;
      if (clr_pend_q | clr_edge) state_d = CLEAR;
      else if (btnL)             state_d = DRAW;
      else if (btnR)             state_d = ERASE;
      else                       state_d = IDLE;
      cur_x_d  = mouseX;
      cur_y_d  = mouseY;
      colour_d = palette(colSel);
      if (sizeUp && !sizeDn && size_q != SW'(MAX_SIZE))
        size_d = size_q + SW'(1);
      else if (sizeDn && !sizeUp && size_q != SW'(1))
        size_d = size_q - SW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      vs_q       <= 1'b1;
      clr_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      size_q     <= SW'(1);
      colour_q   <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= VS;
      clr_q      <= btnClr;
      clr_pend_q <= clr_pend_d;
      size_q     <= size_d;
      colour_q   <= colour_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
    end
  end

  logic [10:0] dx, dy, adx, ady;
  logic        in_canvas;

  always_comb begin
    dx        = {1'b0, xPos} - {1'b0, cur_x_q};
    dy        = {1'b0, yPos} - {1'b0, cur_y_q};
    adx       = dx[10] ? (11'd0 - dx) : dx;
    ady       = dy[10] ? (11'd0 - dy) : dy;
    in_canvas = ({1'b0, xPos} >= X_LO) && ({1'b0, xPos} < X_HI) &&
                ({1'b0, yPos} >= Y_LO) && ({1'b0, yPos} < Y_HI);
  end

  state_t      sel_state;
  logic        sel_in, sel_hit;
  logic [23:0] sel_colour, sel_rc;
  logic [9:0]  sel_x, sel_y;

`ifdef BRUSH_ROUND_EN
  logic [21:0] dx2_q, dx2_d, dy2_q, dy2_d, sz2_q, sz2_d;
  logic        in_q;
  state_t      st_p_q;
  logic [23:0] col_p_q, rc_p_q;
  logic [9:0]  x_p_q, y_p_q;

  always_comb begin
    dx2_d = 22'(adx) * 22'(adx);
    dy2_d = 22'(ady) * 22'(ady);
    sz2_d = 22'(size_q) * 22'(size_q);
  end

  // squares and everything the output mux needs travel together one stage
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dx2_q   <= '0;
      dy2_q   <= '0;
      sz2_q   <= '0;
      in_q    <= 1'b0;
      st_p_q  <= IDLE;
      col_p_q <= '0;
      rc_p_q  <= '0;
      x_p_q   <= '0;
      y_p_q   <= '0;
    end else begin
      dx2_q   <= dx2_d;
      dy2_q   <= dy2_d;
      sz2_q   <= sz2_d;
      in_q    <= in_canvas;
      st_p_q  <= state_q;
      col_p_q <= colour_q;
      rc_p_q  <= {Rc, Gc, Bc};
      x_p_q   <= xPos;
      y_p_q   <= yPos;
    end
  end

  always_comb begin
    sel_state  = st_p_q;
    sel_in     = in_q;
    sel_hit    = in_q && (({1'b0, dx2_q} + {1'b0, dy2_q}) <= {1'b0, sz2_q});
    sel_colour = col_p_q;
    sel_rc     = rc_p_q;
    sel_x      = x_p_q;
    sel_y      = y_p_q;
  end
`else
  always_comb begin
    sel_state  = state_q;
    sel_in     = in_canvas;
    sel_hit    = in_canvas && (adx <= 11'(size_q)) && (ady <= 11'(size_q));
    sel_colour = colour_q;
    sel_rc     = {Rc, Gc, Bc};
    sel_x      = xPos;
    sel_y      = yPos;
  end
`endif

  logic [23:0] rgb_q, rgb_d;
  logic [9:0]  x_out_q, y_out_q;

  always_comb begin
    rgb_d = sel_rc;
    case (sel_state)
      CLEAR:   if (sel_in)  rgb_d = 24'hFFFFFF;
      DRAW:    if (sel_hit) rgb_d = sel_colour;
      ERASE:   if (sel_hit) rgb_d = 24'hFFFFFF;
      default: rgb_d = sel_rc;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb_q   <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      rgb_q   <= rgb_d;
      x_out_q <= sel_x;
      y_out_q <= sel_y;
    end
  end

  assign {Ri, Gi, Bi} = rgb_q;
  assign xOut = x_out_q;
  assign yOut = y_out_q;
endmodule

// File: tb/tb_brush_painter.sv
// Bench for brush_painter: directed scenarios plus random stimulus against a frame-level model.
module tb_brush_painter;
  localparam int X0 = 100, Y0 = 100, W = 440, H = 280, MAXS = 15;
`ifdef BRUSH_ROUND_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int M_IDLE = 0, M_DRAW = 1, M_ERASE = 2, M_CLEAR = 3;
  localparam logic [23:0] RC0 = 24'h123456;

  logic       Clk, Reset_n, VS;
  logic [9:0] xPos, yPos, mouseX, mouseY, xOut, yOut;
  logic [7:0] Rc, Gc, Bc, Ri, Gi, Bi;
  logic       btnL, btnR, btnClr, sizeUp, sizeDn;
  logic [2:0] colSel;

  brush_painter #(.CANVAS_X0(X0), .CANVAS_Y0(Y0), .CANVAS_W(W), .CANVAS_H(H),
                  .MAX_SIZE(MAXS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .VS(VS), .xPos(xPos), .yPos(yPos),
    .Rc(Rc), .Gc(Gc), .Bc(Bc), .mouseX(mouseX), .mouseY(mouseY),
    .btnL(btnL), .btnR(btnR), .btnClr(btnClr), .colSel(colSel),
    .sizeUp(sizeUp), .sizeDn(sizeDn), .Ri(Ri), .Gi(Gi), .Bi(Bi),
    .xOut(xOut), .yOut(yOut));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // frame-level model of the painter
  int m_mode, m_size, m_cx, m_cy;
  bit m_pend, m_vs, m_clr;
  logic [23:0] m_col;
  logic [43:0] pipe[$];

  function automatic logic [23:0] pal(input int i);
    logic [23:0] t[8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                          24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
    return t[i];
  endfunction

  function automatic logic [43:0] expected_pixel();
    int dx = int'(xPos) - m_cx;
    int dy = int'(yPos) - m_cy;
    bit inc = (int'(xPos) >= X0) && (int'(xPos) < X0 + W) &&
              (int'(yPos) >= Y0) && (int'(yPos) < Y0 + H);
    bit hit;
    logic [23:0] rgb = {Rc, Gc, Bc};
`ifdef BRUSH_ROUND_EN
    hit = inc && (dx * dx + dy * dy <= m_size * m_size);
`else
    hit = inc && (dx <= m_size) && (-dx <= m_size) && (dy <= m_size) && (-dy <= m_size);
`endif
    if (m_mode == M_CLEAR && inc)      rgb = 24'hFFFFFF;
    else if (m_mode == M_DRAW && hit)  rgb = m_col;
    else if (m_mode == M_ERASE && hit) rgb = 24'hFFFFFF;
    return {rgb, xPos, yPos};
  endfunction

  task automatic model_edge();
    bit fb = m_vs && !VS;
    bit edge_c = btnClr && !m_clr;
    if (fb) begin
      if (m_pend || edge_c) m_mode = M_CLEAR;
      else if (btnL)        m_mode = M_DRAW;
      else if (btnR)        m_mode = M_ERASE;
      else                  m_mode = M_IDLE;
      m_pend = 0;
      m_cx = int'(mouseX);
      m_cy = int'(mouseY);
      m_col = pal(int'(colSel));
      if (sizeUp && !sizeDn && m_size < MAXS)      m_size++;
      else if (sizeDn && !sizeUp && m_size > 1)    m_size--;
    end else if (edge_c) m_pend = 1;
    m_vs = VS;
    m_clr = btnClr;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_size = 1; m_cx = 0; m_cy = 0;
    m_pend = 0; m_vs = 1; m_clr = 0; m_col = '0;
    pipe.delete();
    repeat (LAT - 1) pipe.push_back('0);
  endtask

  // one clock: predict, advance model, then compare the DUT output after the edge
  task automatic cycle();
    logic [43:0] e;
    pipe.push_back(expected_pixel());
    model_edge();
    @(posedge Clk);
    #1;
    e = pipe.pop_front();
    check("pix", {4'h0, Ri, Gi, Bi, xOut, yOut}, {4'h0, e});
  endtask

  task automatic reset_dut();
    Reset_n = 1'b0;
    #1;
    check("reset", {4'h0, Ri, Gi, Bi, xOut, yOut}, '0);
    model_reset();
    @(posedge Clk);
    #3;
    Reset_n = 1'b1;
  endtask

  task automatic frame_boundary();
    VS = 1'b0; cycle();
    VS = 1'b1; cycle();
  endtask

  task automatic clr_pulse();
    btnClr = 1'b1; cycle();
    btnClr = 1'b0; cycle();
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] exp_rgb);
    xPos = x; yPos = y; {Rc, Gc, Bc} = RC0;
    repeat (LAT) cycle();
    check(tag, {4'h0, Ri, Gi, Bi, xOut, yOut}, {4'h0, exp_rgb, x, y});
  endtask

  initial begin
    Reset_n = 1'b1; VS = 1'b1; xPos = '0; yPos = '0; {Rc, Gc, Bc} = '0;
    mouseX = '0; mouseY = '0; btnL = 0; btnR = 0; btnClr = 0;
    colSel = '0; sizeUp = 0; sizeDn = 0;
    model_reset();
    #2;
    reset_dut();

    probe("passthru_after_reset", 10'd200, 10'd200, RC0);

    btnL = 1; colSel = 3'd2; mouseX = 10'd300; mouseY = 10'd200;
    frame_boundary();
    probe("draw_hit", 10'd301, 10'd200, 24'hFF0000);
`ifndef BRUSH_ROUND_EN
    probe("draw_corner", 10'd301, 10'd201, 24'hFF0000);
`endif
    probe("draw_miss", 10'd302, 10'd200, RC0);

    btnR = 1;
    frame_boundary();
    probe("draw_beats_erase", 10'd300, 10'd200, 24'hFF0000);
    btnL = 0;
    frame_boundary();
    probe("erase_hit", 10'd300, 10'd200, 24'hFFFFFF);

    btnR = 0;
    clr_pulse();
    frame_boundary();
    probe("clear_tl", 10'd100, 10'd100, 24'hFFFFFF);
    probe("clear_br", 10'd539, 10'd379, 24'hFFFFFF);
    probe("clear_right_out", 10'd540, 10'd200, RC0);
    probe("clear_outside", 10'd50, 10'd50, RC0);
    frame_boundary();
    probe("idle_after_clear", 10'd300, 10'd200, RC0);

    btnL = 1; colSel = 3'd4; sizeUp = 1;
    repeat (20) frame_boundary();
    sizeUp = 0;
    probe("size_max_hit", 10'd315, 10'd200, 24'h0000FF);
    probe("size_max_miss", 10'd316, 10'd200, RC0);

    mouseX = 10'd95; mouseY = 10'd150; sizeDn = 1;
    repeat (5) frame_boundary();
    sizeDn = 0;
    probe("clip_left", 10'd99, 10'd150, RC0);
    probe("clip_edge", 10'd100, 10'd150, 24'h0000FF);
    probe("clip_in", 10'd105, 10'd150, 24'h0000FF);

    mouseX = 10'd300; mouseY = 10'd200; sizeDn = 1;
    repeat (5) frame_boundary();
    sizeDn = 0;
    probe("size5_hit", 10'd303, 10'd204, 24'h0000FF);
`ifdef BRUSH_ROUND_EN
    probe("round_miss", 10'd304, 10'd204, RC0);
`else
    probe("square_hit", 10'd304, 10'd204, 24'h0000FF);
`endif

    btnClr = 1; VS = 1'b0; cycle();
    btnClr = 0; VS = 1'b1; cycle();
    probe("clr_same_fb", 10'd100, 10'd100, 24'hFFFFFF);

    reset_dut();
    probe("idle_after_reset", 10'd200, 10'd200, RC0);

    for (int i = 0; i < 3000; i++) begin
      VS = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        btnL = 1'($urandom); btnR = 1'($urandom); btnClr = 1'($urandom);
        sizeUp = 1'($urandom); sizeDn = 1'($urandom); colSel = 3'($urandom);
        mouseX = 10'($urandom_range(60, 600)); mouseY = 10'($urandom_range(60, 420));
      end
      if ($urandom_range(0, 1) == 0) begin
        int vx = m_cx + int'($urandom_range(0, 40)) - 20;
        int vy = m_cy + int'($urandom_range(0, 40)) - 20;
        xPos = 10'((vx < 0) ? 0 : vx);
        yPos = 10'((vy < 0) ? 0 : vy);
      end else begin
        xPos = 10'($urandom_range(0, 700));
        yPos = 10'($urandom_range(0, 500));
      end
      {Rc, Gc, Bc} = 24'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
